// File: rtl/miner_pkg.sv
// Shared constants and types for the nonce reporting path downstream of the miner.
package miner_pkg;

  localparam int unsigned NONCE_W     = 32;
  localparam int unsigned FRAME_BYTES = 5;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StByte
  } rpt_state_t;

endpackage

// File: rtl/nonce_fifo.sv
// Nonce queue with synchronous flush; pointers carry one extra bit so full and empty differ.
module nonce_fifo
  import miner_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [NONCE_W-1:0] data_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [NONCE_W-1:0] data_o,
  output logic [Aw:0]        level_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam logic [Aw:0] DepthL = (Aw + 1)'(Depth);

  logic [NONCE_W-1:0] mem_q [Depth];
  logic [Aw:0]        wptr_q, rptr_q;
  logic               push_ok, pop_ok;

  always_comb begin
    level_o = wptr_q - rptr_q;
    full_o  = (level_o == DepthL);
    empty_o = (level_o == '0);
    data_o  = mem_q[rptr_q[Aw-1:0]];
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    push_ok = push_i && (!full_o || pop_i);
    pop_ok  = pop_i && !empty_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wptr_q[Aw-1:0]] <= data_i;
  end

endmodule

// File: rtl/nonce_reporter.sv
// Queues nonces from miner hits and sends each as a sync byte plus four nonce bytes, LSB first.
module nonce_reporter
  import miner_pkg::*;
#(
  parameter int unsigned        DEPTH        = 4,
  parameter logic [NONCE_W-1:0] NONCE_OFFSET = '0,
  parameter logic [7:0]         SYNC_BYTE    = 8'hAA
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   found,
  input  logic [NONCE_W-1:0]     result,
  input  logic                   flush,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic [7:0]             drop_count
);

  localparam logic [1:0] LastIdx = 2'(FRAME_BYTES - 2);

  rpt_state_t         state_q, state_d;
  logic [NONCE_W-1:0] sr_q, sr_d;
  logic [1:0]         idx_q, idx_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_q, drop_d;

  logic               push, pop, drop, fifo_full, fifo_empty;
  logic [NONCE_W-1:0] fifo_dout;

  // Flush takes priority: a coincident hit is discarded silently and nothing is popped.
  assign push = found && !flush;
  assign pop  = (state_q == StIdle) && !fifo_empty && !flush;
  assign drop = push && fifo_full && !pop;

  nonce_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (result - NONCE_OFFSET),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (fifo_dout),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          sr_d       = fifo_dout;
          tx_data_d  = SYNC_BYTE;
          tx_valid_d = 1'b1;
          state_d    = StHdr;
        end
      end
      StHdr: begin
        if (tx_ready) begin
          tx_data_d = sr_q[7:0];
          sr_d      = sr_q >> 8;
          idx_d     = '0;
          state_d   = StByte;
        end
      end
      StByte: begin
        if (tx_ready) begin
          if (idx_q == LastIdx) begin
            tx_valid_d = 1'b0;
            state_d    = StIdle;
          end else begin
            tx_data_d = sr_q[7:0];
            sr_d      = sr_q >> 8;
            idx_d     = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign busy       = (state_q != StIdle) || (fifo_level != '0);

endmodule

// File: tb/tb_nonce_reporter.sv
// Scoreboarded bench: expected frame bytes are queued at stimulus time and popped on link accepts.
module tb_nonce_reporter;

  logic        clk = 1'b0;
  logic        rst_n, found, found_b, flush, tx_ready;
  logic [31:0] result;
  logic [7:0]  tx_data, tx_data_b, drop_count, drop_count_b;
  logic        tx_valid, tx_valid_b, busy, busy_b, overflow, overflow_b;
  logic [2:0]  fifo_level, fifo_level_b;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b[$];
  logic [7:0] e_a, e_b;

  always #5 clk = ~clk;

  nonce_reporter #(
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .found      (found),
    .result     (result),
    .flush      (flush),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  nonce_reporter #(
    .DEPTH        (4),
    .NONCE_OFFSET (32'd2)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .found      (found_b),
    .result     (result),
    .flush      (flush),
    .tx_data    (tx_data_b),
    .tx_valid   (tx_valid_b),
    .tx_ready   (tx_ready),
    .busy       (busy_b),
    .fifo_level (fifo_level_b),
    .overflow   (overflow_b),
    .drop_count (drop_count_b)
  );

  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stream: got byte %h, want no byte", tx_data);
      end else begin
        e_a = exp_q.pop_front();
        if (tx_data !== e_a) begin
          bad++;
          $display("FAIL stream: got %h want %h", tx_data, e_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && tx_valid_b && tx_ready) begin
      total++;
      if (exp_b.size() == 0) begin
        bad++;
        $display("FAIL stream_off: got byte %h, want no byte", tx_data_b);
      end else begin
        e_b = exp_b.pop_front();
        if (tx_data_b !== e_b) begin
          bad++;
          $display("FAIL stream_off: got %h want %h", tx_data_b, e_b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [31:0] n);
    exp_q.push_back(8'hAA);
    for (int i = 0; i < 4; i++) exp_q.push_back(n[8*i +: 8]);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy && !tx_valid && exp_q.size() == 0) break;
      tick();
    end
    total++;
    if (busy || tx_valid || exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: busy=%b valid=%b pending=%0d, want 0/0/0", busy, tx_valid, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; found = 1'b0; found_b = 1'b0; flush = 1'b0; tx_ready = 1'b1; result = '0;
    tick(); tick();
    total++; if (tx_valid !== 1'b0)   begin bad++; $display("FAIL rst_valid: got %b want 0", tx_valid); end
    total++; if (tx_data !== 8'h00)   begin bad++; $display("FAIL rst_data: got %h want 00", tx_data); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL rst_drops: got %0d want 0", drop_count); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    tick(); found = 1'b1; result = 32'h12345678; push_frame(32'h12345678);
    tick(); found = 1'b0;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL lat_k1: valid got %b want 0", tx_valid); end
    tick();
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hAA) begin
      bad++; $display("FAIL lat_k2: got valid=%b data=%h want 1/AA", tx_valid, tx_data);
    end
    repeat (5) tick();
    total++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL end_k7: busy=%b valid=%b pending=%0d want 0/0/0", busy, tx_valid, exp_q.size());
    end
  endtask

  task automatic test_stall();
    tick(); found = 1'b1; result = 32'h12345678; push_frame(32'h12345678);
    tick(); found = 1'b0;
    tick(); tick(); tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h56) begin
        bad++; $display("FAIL stall_hold: cyc %0d got valid=%b data=%h want 1/56", i, tx_valid, tx_data);
      end
      tick();
    end
    tx_ready = 1'b1;
    wait_idle(20);
  endtask

  task automatic test_overflow();
    tx_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(); found = 1'b1; result = 32'(i);
    end
    tick(); found = 1'b0;
    for (int i = 1; i <= 5; i++) push_frame(32'(i));
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
    total++; if (overflow !== 1'b1)   begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    total++; if (drop_count !== 8'd1) begin bad++; $display("FAIL ovf_drops: got %0d want 1", drop_count); end
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hAA) begin
      bad++; $display("FAIL ovf_hdr: got valid=%b data=%h want 1/AA", tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    wait_idle(80);
  endtask

  task automatic test_flush();
    tx_ready = 1'b1;
    tick(); found = 1'b1; result = 32'hA1A2A3A4; push_frame(32'hA1A2A3A4);
    tick(); result = 32'hB1B2B3B4;
    tick(); result = 32'hC1C2C3C4;
    tick(); found = 1'b0;
    total++; if (fifo_level !== 3'd2) begin bad++; $display("FAIL fl_pre: level got %0d want 2", fifo_level); end
    tick(); tick();
    total++; if (tx_data !== 8'hA2) begin bad++; $display("FAIL fl_byte2: got %h want A2", tx_data); end
    flush = 1'b1; found = 1'b1; result = 32'hD1D2D3D4;
    tick(); flush = 1'b0; found = 1'b0;
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL fl_level: got %0d want 0", fifo_level); end
    total++; if (drop_count !== 8'd1) begin bad++; $display("FAIL fl_drops: got %0d want 1", drop_count); end
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA1) begin
      bad++; $display("FAIL fl_inflight: got valid=%b data=%h want 1/A1", tx_valid, tx_data);
    end
    wait_idle(20);
    repeat (10) tick();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL fl_quiet: valid got %b want 0", tx_valid); end
  endtask

  task automatic test_reset_mid();
    tick(); found = 1'b1; result = 32'hCAFEF00D;
    tick(); found = 1'b0;
    tick();
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL rm_hdr: valid got %b want 1", tx_valid); end
    rst_n = 1'b0;
    tick();
    total++; if (tx_valid !== 1'b0)   begin bad++; $display("FAIL rm_valid: got %b want 0", tx_valid); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rm_busy: got %b want 0", busy); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rm_level: got %0d want 0", fifo_level); end
    total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL rm_ovf: got %b want 0", overflow); end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL rm_drops: got %0d want 0", drop_count); end
    rst_n = 1'b1;
    tick(); found = 1'b1; result = 32'h0BADBEEF; push_frame(32'h0BADBEEF);
    tick(); found = 1'b0;
    wait_idle(20);
  endtask

  task automatic test_offset();
    tick(); found_b = 1'b1; result = 32'h00000001;
    exp_b.push_back(8'hAA);
    for (int i = 0; i < 4; i++) exp_b.push_back(8'hFF);
    tick(); found_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!busy_b && !tx_valid_b && exp_b.size() == 0) break;
      tick();
    end
    total++;
    if (busy_b || tx_valid_b || exp_b.size() != 0) begin
      bad++; $display("FAIL off_drain: busy=%b pending=%0d want 0/0", busy_b, exp_b.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_offset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
